// File: rtl/clock_monitor_pkg.sv
// Shared state encoding and default sizing for the clock monitor.
package clock_monitor_pkg;

  localparam int unsigned DefaultCntW    = 8;
  localparam int unsigned DefaultTimeout = 64;
  // Watchdog width covers the largest legal TIMEOUT (255).
  localparam int unsigned WdW            = 8;

  typedef enum logic [1:0] {
    StIdle,
    StWaitRise,
    StMeas,
    StHold
  } state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a signal already synchronous to clk_in.
module edge_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= d;
    end
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/clock_monitor.sv
// Measures period and high time of a slow clock sampled as data in the clk_in domain,
// with a watchdog that aborts the measurement and a valid/ready result handshake.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int unsigned CNT_W   = DefaultCntW,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             mon_clk,
  input  logic             start,
  output logic             busy,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [WdW-1:0]   WdLast = WdW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             timeout_q, timeout_d;
  logic             rise;

  edge_detect u_edge_detect (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (mon_clk),
    .rise   (rise)
  );

  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    period_d     = period_q;
    high_d       = high_q;
    timeout_d    = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWaitRise;
          wd_d    = '0;
        end
      end

      StWaitRise: begin
        wd_d = wd_q + 1'b1;
        if (wd_q == WdLast) begin
          state_d   = StHold;
          timeout_d = 1'b1;
          period_d  = '0;
          high_d    = '0;
        end else if (rise) begin
          state_d      = StMeas;
          period_cnt_d = CntOne;
          high_cnt_d   = CntOne;
        end
      end

      StMeas: begin
        wd_d = wd_q + 1'b1;
        // A capturing rise wins over a watchdog expiry in the same cycle.
        if (rise) begin
          state_d   = StHold;
          period_d  = period_cnt_q;
          high_d    = high_cnt_q;
          timeout_d = 1'b0;
        end else if (wd_q == WdLast) begin
          state_d   = StHold;
          timeout_d = 1'b1;
          period_d  = '0;
          high_d    = '0;
        end else begin
          if (period_cnt_q != CntMax) begin
            period_cnt_d = period_cnt_q + 1'b1;
          end
          if (mon_clk && (high_cnt_q != CntMax)) begin
            high_cnt_d = high_cnt_q + 1'b1;
          end
        end
      end

      StHold: begin
        if (meas_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wd_q         <= '0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      period_q     <= '0;
      high_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      timeout_q    <= timeout_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign meas_valid = (state_q == StHold);
  assign period     = period_q;
  assign high_time  = high_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: an 8-bit and a 4-bit instance share all inputs.
module tb_clock_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mon_clk = 1'b0;
  logic       start = 1'b0;
  logic       meas_ready = 1'b0;
  logic       busy, meas_valid, timeout;
  logic [7:0] period, high_time;
  logic       busy4, meas_valid4, timeout4;
  logic [3:0] period4, high_time4;

  int tests = 0;
  int fails = 0;
  int hi = 0;
  int lo = 1;
  int ph = 0;

  typedef struct {
    int hi;
    int lo;
    int per;
    int hig;
    int to;
    int per4;
    int hig4;
    int lat;
  } vec_t;

  vec_t vecs[9];

  clock_monitor #(.CNT_W(8), .TIMEOUT(64)) dut (
    .clk_in     (clk),
    .rst        (rst),
    .mon_clk    (mon_clk),
    .start      (start),
    .busy       (busy),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .period     (period),
    .high_time  (high_time),
    .timeout    (timeout)
  );

  clock_monitor #(.CNT_W(4), .TIMEOUT(64)) dut4 (
    .clk_in     (clk),
    .rst        (rst),
    .mon_clk    (mon_clk),
    .start      (start),
    .busy       (busy4),
    .meas_valid (meas_valid4),
    .meas_ready (meas_ready),
    .period     (period4),
    .high_time  (high_time4),
    .timeout    (timeout4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (hi == 0) begin
      mon_clk = 1'b0;
    end else if (lo == 0) begin
      mon_clk = 1'b1;
    end else begin
      ph = (ph + 1) % (hi + lo);
      mon_clk = (ph < hi);
    end
  endtask

  task automatic set_pattern(input int h, input int l);
    hi = h;
    lo = l;
    ph = 0;
    mon_clk = (h != 0);
  endtask

  task automatic run_meas(output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!meas_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("valid_seen", meas_valid, 1);
  endtask

  task automatic transfer();
    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;
    check("xfer_valid", meas_valid, 0);
    check("xfer_busy", busy, 0);
  endtask

  initial begin
    int lat;
    int cnt;
    int stable;
    logic [7:0] sp, sh;
    logic st;

    // hi, lo, period, high, timeout, period4, high4, latency from start edge
    vecs[0] = '{3, 3, 6, 3, 0, 6, 3, 9};
    vecs[1] = '{1, 1, 2, 1, 0, 2, 1, 3};
    vecs[2] = '{5, 2, 7, 5, 0, 7, 5, 11};
    vecs[3] = '{1, 4, 5, 1, 0, 5, 1, 7};
    vecs[4] = '{10, 20, 30, 10, 0, 15, 10, 57};
    vecs[5] = '{10, 10, 20, 10, 0, 15, 10, 37};
    vecs[6] = '{0, 1, 0, 0, 1, 0, 0, 64};
    vecs[7] = '{1, 0, 0, 0, 1, 0, 0, 64};
    vecs[8] = '{40, 40, 0, 0, 1, 0, 0, 64};

    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    check("rst_timeout", timeout, 0);
    check("rst_valid4", meas_valid4, 0);
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 9; i++) begin
      set_pattern(vecs[i].hi, vecs[i].lo);
      repeat (3) tick();
      run_meas(lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_period", i), period, vecs[i].per);
      check($sformatf("v%0d_high", i), high_time, vecs[i].hig);
      check($sformatf("v%0d_timeout", i), timeout, vecs[i].to);
      check($sformatf("v%0d_valid4", i), meas_valid4, 1);
      check($sformatf("v%0d_period4", i), period4, vecs[i].per4);
      check($sformatf("v%0d_high4", i), high_time4, vecs[i].hig4);
      check($sformatf("v%0d_timeout4", i), timeout4, vecs[i].to);
      transfer();
    end

    // Backpressure in HOLD, then values retained in IDLE.
    set_pattern(5, 2);
    repeat (3) tick();
    run_meas(lat);
    sp = period;
    sh = high_time;
    st = timeout;
    stable = 1;
    repeat (10) begin
      tick();
      if (!meas_valid || period != sp || high_time != sh || timeout != st) stable = 0;
    end
    check("hold_stable", stable, 1);
    check("hold_period", period, 7);
    transfer();
    check("idle_keep_period", period, 7);
    check("idle_keep_high", high_time, 5);

    // start held high through WAIT_RISE, MEAS, HOLD and the transfer cycle.
    set_pattern(3, 3);
    repeat (3) tick();
    start = 1'b1;
    tick();
    lat = 0;
    while (!meas_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("ign_valid", meas_valid, 1);
    check("ign_latency", lat, 9);
    check("ign_period", period, 6);
    check("ign_high", high_time, 3);
    repeat (3) tick();
    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;
    start = 1'b0;
    check("ign_xfer_valid", meas_valid, 0);
    check("ign_xfer_busy", busy, 0);
    cnt = 0;
    repeat (20) begin
      tick();
      if (busy || meas_valid) cnt++;
    end
    check("ign_no_second", cnt, 0);

    // Reset in the middle of MEAS.
    set_pattern(10, 20);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (35) tick();
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", meas_valid, 0);
    check("mid_rst_period", period, 0);
    check("mid_rst_high", high_time, 0);
    check("mid_rst_timeout", timeout, 0);
    repeat (2) tick();
    rst = 1'b0;
    cnt = 0;
    repeat (80) begin
      tick();
      if (meas_valid) cnt++;
    end
    check("post_rst_no_valid", cnt, 0);
    set_pattern(3, 3);
    repeat (3) tick();
    run_meas(lat);
    check("post_rst_latency", lat, 9);
    check("post_rst_period", period, 6);
    check("post_rst_high", high_time, 3);
    check("post_rst_timeout", timeout, 0);
    transfer();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clock_monitor.md
CLOCK_MONITOR -- requirements
Module: clock_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the period and high_time result fields.
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum clk_in cycles from start to capture; legal range 2..255.
REQ-003 SHALL have port clk_in  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mon_clk  input  1  divided clock under measurement, registered in the clk_in domain, sampled as data only and never used as a clock.
REQ-006 SHALL have port start  input  1  single-cycle request to begin one measurement.
REQ-007 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-008 SHALL have port meas_valid  output  1  result available.
REQ-009 SHALL have port meas_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port period  output  CNT_W  clk_in cycles between two consecutive mon_clk rising edges.
REQ-011 SHALL have port high_time  output  CNT_W  clk_in cycles with mon_clk high within that period.
REQ-012 SHALL have port timeout  output  1  measurement aborted by the watchdog.

Function
REQ-013 SHALL register mon_clk every cycle into prev; rise = mon_clk AND NOT prev.
REQ-014 SHALL implement FSM states IDLE, WAIT_RISE, MEAS, HOLD.
REQ-015 SHALL go IDLE->WAIT_RISE on start and clear the watchdog counter to 0.
REQ-016 SHALL ignore start in any state other than IDLE, including HOLD during a transfer cycle.
REQ-017 SHALL go WAIT_RISE->MEAS on the first rise and load period_cnt=1 and high_cnt=1.
REQ-018 SHALL, in MEAS on a cycle without rise, increment period_cnt by 1 and increment high_cnt by 1 if mon_clk=1.
REQ-019 SHALL saturate period_cnt and high_cnt at 2^CNT_W-1 with no wrap-around.
REQ-020 SHALL, on a rise in MEAS, register period=period_cnt, high_time=high_cnt, timeout=0 and go to HOLD.
REQ-021 SHALL assert meas_valid the cycle after the capturing rise, which is a latency of 1 cycle.
REQ-022 SHALL increment the watchdog once per cycle in WAIT_RISE and MEAS.
REQ-023 SHALL, when the watchdog reaches TIMEOUT-1 without a capture, go to HOLD with timeout=1, period=0 and high_time=0.
REQ-024 SHALL give capture priority over timeout when both occur in the same cycle.
REQ-025 SHALL hold meas_valid and the result outputs stable in HOLD until meas_valid AND meas_ready.
REQ-026 SHALL, on transfer, deassert meas_valid next cycle and go to IDLE, with busy low that cycle.
REQ-027 SHALL keep period, high_time and timeout holding their last values in IDLE.

Reset
REQ-028 SHALL, while rst=1, asynchronously force state=IDLE, prev=0, counters=0, busy=0, meas_valid=0, period=0, high_time=0 and timeout=0.
REQ-029 SHALL abandon a measurement in progress when reset is asserted mid-operation, with no result produced after reset.
REQ-030 SHALL make the first rise evaluation after reset use prev=0, so mon_clk=1 on the first cycle after reset counts as a rise.

Structure
REQ-031 SHALL place the state encoding and the CNT_W/TIMEOUT defaults in shared package clock_monitor_pkg.
REQ-032 SHALL implement the prev register and rise logic as sub-module edge_detect, containing clk_in, rst, d and rise.

Verification
REQ-033 SHALL cover: mon_clk 3 high/3 low repeating, start -> meas_valid with period=6, high_time=3, timeout=0, one cycle after the second rise.
REQ-034 SHALL cover: mon_clk stuck 0, TIMEOUT=64, start -> meas_valid 64 cycles after start with timeout=1, period=0, high_time=0.
REQ-035 SHALL cover: meas_ready held low 10 cycles in HOLD -> outputs unchanged; ready=1 -> transfer, meas_valid=0 and busy=0 next cycle.
REQ-036 SHALL cover: start pulsed in WAIT_RISE, MEAS and HOLD -> ignored, with exactly one result produced.
REQ-037 SHALL cover: CNT_W=4, mon_clk period 20 with 10 high -> period=15, high_time=10.
REQ-038 SHALL cover: rst pulsed mid-MEAS -> all outputs 0 immediately, meas_valid never asserted, and a new start measures correctly.
